pong_tick_scheduler: RTL and testbench
======================================

# pong_tick_scheduler

Frame sequencer for the Pong game loop. It generates the game tick from `CLOCK_50` with a divisor that shortens as the rally speeds up, and on each tick runs the paddle-update, ball-update and collision units in a fixed order using req/ack handshakes. It sits between the clock and the game-logic units and owns the game's speed level.

## Interface
- `BASE_DIV`, 150_000: tick period in clocks at level 0.
- `SPEED_STEP`, 10_000: period reduction per level.
- `MIN_DIV`, 50_000: smallest allowed period. Level saturates at `LVL_MAX = (BASE_DIV-MIN_DIV)/SPEED_STEP`.
- `HITS_PER_LEVEL`, 4: paddle hits needed per level increment.
- `CW`, 26: divider counter width.
- `CLOCK_50` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `run` in 1: game running. When low, no ticks are generated.
- `paddle_ack`, `ball_ack`, `coll_ack` in 1 each: phase-complete acknowledgements.
- `hit`, `miss` in 1 each: collision results. Sampled only with `coll_ack`.
- `paddle_req`, `ball_req`, `coll_req` out 1 each: phase requests, level-held.
- `frame_done` out 1: one-cycle pulse at the end of each frame.
- `tick_overrun` out 1: one-cycle pulse when a tick arrives while a frame is still in progress.
- `level` out 3: current speed level.

## Operation
- Divider counts 0..`div`-1 while `run`=1. Tick is asserted when count==`div`-1, and the counter wraps to 0. While `run`=0 the counter is held at 0.
- Period: `div = max(BASE_DIV - level*SPEED_STEP, MIN_DIV)`. It is registered, and a new value takes effect only at the next wrap. The current period is never truncated.
- FSM states: IDLE -> PADDLE -> BALL -> COLL -> DONE -> IDLE.
- IDLE: on tick, go to PADDLE.
- PADDLE, BALL, COLL: the matching req equals (state==phase). The FSM advances on the edge where the matching ack is 1. Acks in other states are ignored.
- In COLL, the edge with `coll_ack` also latches `hit` and `miss`. If both are 1, `miss` wins.
- DONE: lasts one cycle and asserts `frame_done`.
  - On hit: increment `hit_cnt`. When it reaches `HITS_PER_LEVEL`, clear it and increment `level`, saturating at `LVL_MAX`.
  - On miss: clear `level` and `hit_cnt`.
- Tick in any state other than IDLE: pulse `tick_overrun`, drop the tick, and keep the counter running.
- `run` falling mid-frame: the current frame completes and no new ticks follow.
- Reset: all outputs are 0, state is IDLE, count is 0, `hit_cnt` is 0, and `div` is `BASE_DIV`.
- Reset mid-frame: every req is low and `level` is 0 on the cycle after the reset edge. Pending acks are discarded.

## Timing
- Tick cycle T: `paddle_req` is high at T+1.
- Each ack takes effect on the edge it is sampled. The next req rises one cycle later, with no idle gap between phases.
- Minimum frame: 4 cycles from tick to `frame_done` when acks are tied high.
- A `level` change is visible the cycle after DONE. The new `div` applies from the following wrap.
- `tick_overrun` and `frame_done` never last more than one cycle.
- First tick after `run` rises: `div` cycles later.

## Structure
- Package `pong_pkg` holds:
  - the state enum (IDLE/PADDLE/BALL/COLL/DONE),
  - default `BASE_DIV`, `SPEED_STEP`, `MIN_DIV`, `HITS_PER_LEVEL`,
  - `LEVEL_W`=3.
- Sub-module `tick_divider` is a programmable-period counter with inputs `enable` and `div`, and output `tick`. It loads `div` at wrap.
- The FSM, hit counter and level logic stay in the top level.

## Test plan
Parameters for all scenarios: `BASE_DIV`=20, `SPEED_STEP`=4, `MIN_DIV`=8, `HITS_PER_LEVEL`=2, giving `LVL_MAX`=3.
- Reset/idle: `reset`=1 for 3 cycles, then `run`=0 for 100 cycles -> all outputs 0, `level`=0.
- Basic frame: `run`=1, all acks tied high, `hit`=`miss`=0 -> `paddle_req` one cycle after each tick, `frame_done` every 20 cycles, 4 cycles after each tick.
- Speed-up: `hit`=1 on every frame -> `level` goes 1, 2, 3 after frames 2, 4, 6. `frame_done` spacing becomes 16, 12, 8. `level` stays at 3 through frame 10.
- Miss: at `level`=2, assert `miss` (with `hit`=1) on one frame -> `level`=0, and the period is 20 from the next wrap.
- Overrun: hold `ball_ack` low for 30 cycles -> exactly one `tick_overrun` pulse, no second `paddle_req` until the current frame's DONE, and the next frame starts on the following tick.
- Reset mid-frame: assert `reset` while in BALL at `level`=2 -> the cycle after the reset edge has `ball_req`=0, `level`=0, and no `frame_done`.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong frame sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PADDLE,
    ST_BALL,
    ST_COLL,
    ST_DONE
  } state_t;

  localparam int DEF_BASE_DIV       = 150_000;
  localparam int DEF_SPEED_STEP     = 10_000;
  localparam int DEF_MIN_DIV        = 50_000;
  localparam int DEF_HITS_PER_LEVEL = 4;
  localparam int LEVEL_W            = 3;

  // The level register is LEVEL_W bits, so the saturation point is capped at its range.
  function automatic int lvl_sat(input int base_div, input int min_div, input int step);
    int raw;
    raw = (base_div - min_div) / step;
    return (raw > (2 ** LEVEL_W) - 1) ? (2 ** LEVEL_W) - 1 : raw;
  endfunction

endpackage

// File: rtl/pong_tick_scheduler_tick_divider.sv
// Programmable-period tick generator; a new period is adopted only at wrap.
module tick_divider #(
  parameter int CW      = 26,
  parameter int RST_DIV = 150_000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic [CW-1:0] i_div,
  output logic          o_tick
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_div;
  logic          w_wrap;

  assign w_wrap = (r_cnt == r_div - CW'(1));
  assign o_tick = i_enable && w_wrap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_div <= CW'(RST_DIV);
    end else if (!i_enable) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_div <= i_div;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pong_tick_scheduler.sv
// Pong frame sequencer: per tick runs paddle, ball and collision phases and tracks speed level.
//   state  | meaning
//   IDLE   | waiting for a tick
//   PADDLE | paddle_req high until paddle_ack
//   BALL   | ball_req high until ball_ack
//   COLL   | coll_req high until coll_ack; hit/miss latched
//   DONE   | frame_done pulse, hit counter / level update
module pong_tick_scheduler
  import pong_pkg::*;
#(
  parameter int BASE_DIV       = DEF_BASE_DIV,
  parameter int SPEED_STEP     = DEF_SPEED_STEP,
  parameter int MIN_DIV        = DEF_MIN_DIV,
  parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
  parameter int CW             = 26
) (
  input  logic               i_clock_50,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_paddle_ack,
  input  logic               i_ball_ack,
  input  logic               i_coll_ack,
  input  logic               i_hit,
  input  logic               i_miss,
  output logic               o_paddle_req,
  output logic               o_ball_req,
  output logic               o_coll_req,
  output logic               o_frame_done,
  output logic               o_tick_overrun,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int LVL_MAX = lvl_sat(BASE_DIV, MIN_DIV, SPEED_STEP);
  localparam int HW      = $clog2(HITS_PER_LEVEL + 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_hit;
  logic               r_miss;
  logic [LEVEL_W-1:0] r_level;
  logic [HW-1:0]      r_hit_cnt;
  logic [CW-1:0]      w_div;
  logic               w_tick;
  int                 w_raw;

  always_comb begin
    w_raw = BASE_DIV - int'(r_level) * SPEED_STEP;
    w_div = CW'(MIN_DIV);
    if (w_raw > MIN_DIV) w_div = CW'(w_raw);
  end

  tick_divider #(
    .CW      (CW),
    .RST_DIV (BASE_DIV)
  ) u_div (
    .i_clk    (i_clock_50),
    .i_reset  (i_reset),
    .i_enable (i_run),
    .i_div    (w_div),
    .o_tick   (w_tick)
  );

  always_ff @(posedge i_clock_50) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_level   <= '0;
      r_hit_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_COLL && i_coll_ack) begin
        r_hit  <= i_hit;
        r_miss <= i_miss;
      end
      // Miss takes priority over a simultaneous hit.
      if (r_state == ST_DONE) begin
        if (r_miss) begin
          r_level   <= '0;
          r_hit_cnt <= '0;
        end else if (r_hit) begin
          if (r_hit_cnt == HW'(HITS_PER_LEVEL - 1)) begin
            r_hit_cnt <= '0;
            if (r_level != LEVEL_W'(LVL_MAX)) r_level <= r_level + LEVEL_W'(1);
          end else begin
            r_hit_cnt <= r_hit_cnt + HW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    o_paddle_req   = 1'b0;
    o_ball_req     = 1'b0;
    o_coll_req     = 1'b0;
    o_frame_done   = 1'b0;
    o_tick_overrun = w_tick && (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:   if (w_tick) w_next = ST_PADDLE;
      ST_PADDLE: begin
        o_paddle_req = 1'b1;
        if (i_paddle_ack) w_next = ST_BALL;
      end
      ST_BALL: begin
        o_ball_req = 1'b1;
        if (i_ball_ack) w_next = ST_COLL;
      end
      ST_COLL: begin
        o_coll_req = 1'b1;
        if (i_coll_ack) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_frame_done = 1'b1;
        w_next       = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  assign o_level = r_level;

endmodule

// File: tb/tb_pong_tick_scheduler.sv
// Scoreboard bench for pong_tick_scheduler with a small speed configuration (LVL_MAX = 3).
module tb_pong_tick_scheduler;

  logic       clk = 1'b0;
  logic       i_reset, i_run, i_paddle_ack, i_ball_ack, i_coll_ack, i_hit, i_miss;
  logic       o_paddle_req, o_ball_req, o_coll_req, o_frame_done, o_tick_overrun;
  logic [2:0] o_level;

  always #5 clk = ~clk;

  pong_tick_scheduler #(
    .BASE_DIV       (20),
    .SPEED_STEP     (4),
    .MIN_DIV        (8),
    .HITS_PER_LEVEL (2),
    .CW             (26)
  ) dut (
    .i_clock_50     (clk),
    .i_reset        (i_reset),
    .i_run          (i_run),
    .i_paddle_ack   (i_paddle_ack),
    .i_ball_ack     (i_ball_ack),
    .i_coll_ack     (i_coll_ack),
    .i_hit          (i_hit),
    .i_miss         (i_miss),
    .o_paddle_req   (o_paddle_req),
    .o_ball_req     (o_ball_req),
    .o_coll_req     (o_coll_req),
    .o_frame_done   (o_frame_done),
    .o_tick_overrun (o_tick_overrun),
    .o_level        (o_level)
  );

  // interval: cycles since previous frame_done (or since run rose); lat: paddle_req rise to frame_done
  typedef struct {
    int interval;
    int level;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, t_last = 0, t_paddle = 0, ov_cnt = 0;
  logic prev_paddle = 1'b0, prev_done = 1'b0, prev_ov = 1'b0;

  // frames 1..22: hit, miss, interval, level seen during frame_done
  int v_hit [22] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int v_miss[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
  int v_iv  [22] = '{23, 20, 20, 20, 20, 20, 16, 16, 12, 12, 8, 8, 8, 8, 8, 20, 20, 16, 16, 12, 20, 20};
  int v_lv  [22] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 0, 0, 1, 1, 2, 0, 0, 0};
  // frames 25..28 with hit=1
  int w_iv  [4]  = '{20, 20, 20, 16};
  int w_lv  [4]  = '{0, 0, 1, 1};

  function automatic void check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (o_paddle_req && !prev_paddle) t_paddle = cyc;
    if (o_tick_overrun) begin
      ov_cnt++;
      check("overrun_width", int'(prev_ov), 0);
    end
    if (o_frame_done) begin
      check("done_width", int'(prev_done), 0);
      check("frame_done_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("frame_interval", cyc - t_last, e.interval);
        check("frame_level", int'(o_level), e.level);
        check("paddle_to_done", cyc - t_paddle, e.lat);
      end
      t_last = cyc;
    end
    prev_paddle = o_paddle_req;
    prev_done   = o_frame_done;
    prev_ov     = o_tick_overrun;
  end

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (!o_frame_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_in_budget", int'(o_frame_done), 1);
  endtask

  task automatic wait_ball(input int budget);
    int n = 0;
    @(negedge clk);
    while (!o_ball_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ball_req_in_budget", int'(o_ball_req), 1);
  endtask

  initial begin
    i_reset = 1'b1; i_run = 1'b0;
    i_paddle_ack = 1'b0; i_ball_ack = 1'b0; i_coll_ack = 1'b0;
    i_hit = 1'b0; i_miss = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    repeat (100) begin
      @(negedge clk);
      check("idle_outputs",
            int'({o_paddle_req, o_ball_req, o_coll_req, o_frame_done, o_tick_overrun, o_level}), 0);
    end

    // basic frames, speed-up to saturation, misses at level 3 and level 2
    i_paddle_ack = 1'b1; i_ball_ack = 1'b1; i_coll_ack = 1'b1;
    t_last = cyc;
    i_run  = 1'b1;
    for (int i = 0; i < 22; i++) begin
      i_hit  = v_hit[i][0];
      i_miss = v_miss[i][0];
      sb_q.push_back(exp_t'{v_iv[i], v_lv[i], 3});
      wait_done(60);
    end

    // overrun: ball phase stalls across one tick
    i_hit = 1'b0; i_miss = 1'b0;
    i_ball_ack = 1'b0;
    sb_q.push_back(exp_t'{50, 0, 33});
    wait_ball(60);
    repeat (30) @(negedge clk);
    i_ball_ack = 1'b1;
    wait_done(60);
    sb_q.push_back(exp_t'{10, 0, 3});
    wait_done(60);
    check("overrun_pulses", ov_cnt, 1);

    // climb back to level 2
    i_hit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(exp_t'{w_iv[i], w_lv[i], 3});
      wait_done(60);
    end

    // reset while the ball phase is active
    wait_ball(60);
    check("level_before_reset", int'(o_level), 2);
    i_reset = 1'b1;
    @(negedge clk);
    check("rst_ball_req", int'(o_ball_req), 0);
    check("rst_paddle_req", int'(o_paddle_req), 0);
    check("rst_coll_req", int'(o_coll_req), 0);
    check("rst_level", int'(o_level), 0);
    check("rst_frame_done", int'(o_frame_done), 0);
    i_reset = 1'b0;
    i_run   = 1'b0;
    repeat (30) @(negedge clk);

    check("scoreboard_drained", sb_q.size(), 0);
    check("overrun_total", ov_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
